intra_net_reshape: RTL and testbench
====================================

# intra_net_reshape

Parametrised successor to the intra-network transpose/address path. It moves a sequence of tiles from the output buffer (O) to the activation buffer (A). Each tile is either transposed or passed through, with configurable tile height and width. The block generates both address streams, holds a one-tile staging buffer, honours write back-pressure, and pulses `sig_end` once the last tile is written. It sits between the PE-array output buffer and the activation SRAM inside the NPU intra-network.

## Interface
Parameters:
- `ROW_DIM`, 16: lanes per O-buffer row (`data_in` elements).
- `COL_DIM`, 16: lanes per A-buffer row (`data_out` elements). Also the maximum rows loaded per tile.
- `DATA_WIDTH`, 8: bits per element.
- `ADDR_WIDTH`, 10: SRAM address width.
- `TILE_CNT_WIDTH`, 8: width of the tile-count field.
- `MEM_RD_LAT`, 1: O-buffer read latency in cycles, 1..4.

Ports:
- `clk` in 1: single clock. Everything is on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `sig_start` in 1: start pulse. Sampled only in IDLE.
- `mode` in 1: 0 = passthrough, 1 = transpose. Legal only when `ROW_DIM==COL_DIM`.
- `A` in clog2(COL_DIM): rows loaded per tile, minus 1.
- `B` in clog2(ROW_DIM): valid lanes per loaded row, minus 1.
- `num_tiles` in TILE_CNT_WIDTH: tile count, minus 1.
- `O_base_addr`, `A_base_addr` in ADDR_WIDTH: first read and first write address.
- `data_in` in ROW_DIM*DATA_WIDTH: O read data, valid MEM_RD_LAT cycles after `O_rd_en`.
- `O_rd_en` out 1, `O_addr` out ADDR_WIDTH: O read request.
- `A_w_en` out 1, `A_addr` out ADDR_WIDTH, `data_out` out COL_DIM*DATA_WIDTH: A write request.
- `A_w_ready` in 1: a write completes on a cycle where `A_w_en && A_w_ready`.
- `busy` out 1: high from the cycle after an accepted start through the `sig_end` cycle.
- `sig_end` out 1: one-cycle done pulse.

## Operation
- The FSM states are IDLE, LOAD, WAIT, DRAIN and DONE.
- **IDLE:** on `sig_start`, latch `mode`, `A`, `B`, `num_tiles` and both base addresses into internal registers. Go to LOAD.
  - Config inputs are don't-care after the start cycle.
  - `sig_start` in any other state is ignored.
- **LOAD:** assert `O_rd_en` for A+1 consecutive cycles. `O_addr` starts at the read pointer and increments by 1 each cycle.
- **WAIT:** MEM_RD_LAT cycles with `O_rd_en` low. The capture pipeline, a valid shift register of depth MEM_RD_LAT, writes `data_in` into staging row r.
  - Leave WAIT once the last row is captured.
  - The capture path lags LOAD, so capture of rows 0..A overlaps the end of LOAD.
- **DRAIN, transpose:** B+1 writes. Output row j holds lane i = staged[i][j] for i ≤ A. Lanes i > A are zero.
- **DRAIN, passthrough:** A+1 writes. Output row r holds lanes k ≤ B from staged[r][k]. All other lanes are zero.
- **Write handshake:** `A_addr`, `data_out` and `A_w_en` hold stable until the handshake completes. The write pointer increments on each handshake.
- **After the last handshake of a tile:** if tiles remain, go to LOAD; otherwise go to DONE.
- **DONE:** `sig_end` is high for one cycle. Return to IDLE.
- **Pointers:** the read and write pointers continue across tiles. Tile t reads directly after tile t-1's last read address, and writes likewise. Both wrap modulo 2^ADDR_WIDTH.
- **Reset, asserted at any time:**
  - State goes to IDLE.
  - All outputs go to 0: `O_rd_en`, `A_w_en`, `sig_end`, `busy`, `O_addr`, `A_addr`, `data_out`.
  - The staging buffer and capture pipeline are cleared.
  - An in-flight tile is abandoned with no further requests.
- **Staging buffer:** COL_DIM × ROW_DIM × DATA_WIDTH flops. Unloaded rows read as zero. The buffer is cleared at the start of each LOAD.

## Timing
- Start sampled at cycle 0.
- The first `O_rd_en` is at cycle 1. The last is at cycle A+1.
- The first `A_w_en` is at cycle A+2+MEM_RD_LAT.
- With `A_w_ready` held high, one write per cycle follows.
- The next tile's LOAD begins the cycle after the final handshake.
- `sig_end` is asserted the cycle after the final handshake of the last tile.
- Per-tile latency with no back-pressure: (A+1) + MEM_RD_LAT + W, where W = B+1 in transpose mode and A+1 in passthrough mode.
- `O_rd_en` and `A_w_en` are never high in the same cycle.

## Structure
- Shared package `intra_net_pkg` holds:
  - the FSM state enum,
  - the mode constants `MODE_PASS` and `MODE_TRANS`,
  - the MEM_RD_LAT legal range.
- One sub-module, `intra_net_ptr_gen`: the read and write address counters with base load, handshake-gated increment and wrap.
- The FSM, capture pipeline, staging buffer and lane muxing live in the top.

## Test plan
- **Full transpose:** 16×16 transpose, MEM_RD_LAT=1, `A_base_addr`=0x040, `data_in` row r lane i = r*16+i.
  - 16 writes to addresses 0x040..0x04F.
  - Write j, lane i = i*16+j.
  - First `A_w_en` at cycle 18. `sig_end` at cycle 34.
- **Partial transpose:** A=3, B=1.
  - Exactly 4 reads and 2 writes.
  - Write j lanes 0..3 = staged[0..3][j]. Lanes 4..15 = 0.
- **Passthrough with wrap:** 2 tiles (`num_tiles`=1), A=3, B=15, `O_base_addr`=0x3FE, `A_base_addr`=0x3FC.
  - Reads at 0x3FE, 0x3FF, 0x000..0x005.
  - Writes at 0x3FC..0x3FF, 0x000..0x003.
  - Data is unchanged.
- **Back-pressure:** `A_w_ready` low for 3 cycles during write 5.
  - `A_addr` and `data_out` stay stable.
  - No row is skipped or duplicated.
  - `sig_end` arrives 3 cycles later than in the unstalled run.
- **Reset mid-operation:** `reset` low during DRAIN.
  - All outputs are 0 immediately, with no clock edge needed.
  - After release, a new start runs the full-transpose scenario correctly.
- **Start while busy, MEM_RD_LAT=3:** `sig_start` pulsed during LOAD.
  - The pulse is ignored.
  - The transfer runs with the original config.
  - Exactly one `sig_end`.
  - First `A_w_en` is at cycle A+5.

Source files
------------

// File: rtl/intra_net_pkg.sv
// Shared types and constants for the intra-network O->A reshape path.
package intra_net_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic MODE_PASS  = 1'b0;
    localparam logic MODE_TRANS = 1'b1;

    localparam int unsigned MEM_RD_LAT_MIN = 1;
    localparam int unsigned MEM_RD_LAT_MAX = 4;

endpackage

// File: rtl/intra_net_ptr_gen.sv
// Read/write address counters: base load on start, increment per request, natural wrap.
module intra_net_ptr_gen
    import intra_net_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_rd_base,
    input  logic [ADDR_WIDTH-1:0] i_wr_base,
    input  logic                  i_rd_inc,
    input  logic                  i_wr_inc,
    output logic [ADDR_WIDTH-1:0] o_rd_ptr,
    output logic [ADDR_WIDTH-1:0] o_wr_ptr
);

    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (i_load) begin
                r_rd_ptr <= i_rd_base;
            end else if (i_rd_inc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_load) begin
                r_wr_ptr <= i_wr_base;
            end else if (i_wr_inc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

    assign o_rd_ptr = r_rd_ptr;
    assign o_wr_ptr = r_wr_ptr;

endmodule

// File: rtl/intra_net_reshape.sv
// Moves tiles from the O buffer to the A buffer, transposing or passing each through
// a one-tile staging buffer; pointers continue across tiles.
module intra_net_reshape
    import intra_net_pkg::*;
#(
    parameter int unsigned ROW_DIM        = 16,
    parameter int unsigned COL_DIM        = 16,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned TILE_CNT_WIDTH = 8,
    parameter int unsigned MEM_RD_LAT     = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sig_start,
    input  logic                          mode,
    input  logic [$clog2(COL_DIM)-1:0]    A,
    input  logic [$clog2(ROW_DIM)-1:0]    B,
    input  logic [TILE_CNT_WIDTH-1:0]     num_tiles,
    input  logic [ADDR_WIDTH-1:0]         O_base_addr,
    input  logic [ADDR_WIDTH-1:0]         A_base_addr,
    input  logic [ROW_DIM*DATA_WIDTH-1:0] data_in,
    output logic                          O_rd_en,
    output logic [ADDR_WIDTH-1:0]         O_addr,
    output logic                          A_w_en,
    output logic [ADDR_WIDTH-1:0]         A_addr,
    output logic [COL_DIM*DATA_WIDTH-1:0] data_out,
    input  logic                          A_w_ready,
    output logic                          busy,
    output logic                          sig_end
);

    localparam int unsigned AW      = $clog2(COL_DIM);
    localparam int unsigned BW      = $clog2(ROW_DIM);
    localparam int unsigned IW      = (AW > BW) ? AW : BW;
    localparam int unsigned DW      = DATA_WIDTH;
    localparam int unsigned MIN_DIM = (ROW_DIM < COL_DIM) ? ROW_DIM : COL_DIM;
    localparam int unsigned LAT     = (MEM_RD_LAT < MEM_RD_LAT_MIN) ? MEM_RD_LAT_MIN :
                                      (MEM_RD_LAT > MEM_RD_LAT_MAX) ? MEM_RD_LAT_MAX : MEM_RD_LAT;

    state_t                    r_state;
    logic                      r_o_rd_en;
    logic                      r_a_w_en;
    logic                      r_sig_end;
    logic                      r_busy;
    logic                      r_mode;
    logic [AW-1:0]             r_a;
    logic [BW-1:0]             r_b;
    logic [AW-1:0]             r_ld_cnt;
    logic [AW-1:0]             r_cap_row;
    logic [IW-1:0]             r_wr_idx;
    logic [TILE_CNT_WIDTH-1:0] r_num_tiles;
    logic [TILE_CNT_WIDTH-1:0] r_tile_cnt;
    logic [LAT-1:0]            r_vld;
    logic [ROW_DIM*DW-1:0]     r_stage [COL_DIM];

    logic                      w_ptr_load;
    logic                      w_wr_hs;
    logic                      w_cap;
    logic [IW-1:0]             w_last_idx;
    logic [ROW_DIM*DW-1:0]     w_stage_row;
    logic [COL_DIM*DW-1:0]     w_row_mux;

    assign w_ptr_load = (r_state == S_IDLE) && sig_start;
    assign w_wr_hs    = r_a_w_en && A_w_ready;
    assign w_cap      = r_vld[LAT-1];
    assign w_last_idx = (r_mode == MODE_TRANS) ? IW'(r_b) : IW'(r_a);

    intra_net_ptr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ptr_gen (
        .clk       (clk),
        .rst_n     (reset),
        .i_load    (w_ptr_load),
        .i_rd_base (O_base_addr),
        .i_wr_base (A_base_addr),
        .i_rd_inc  (r_o_rd_en),
        .i_wr_inc  (w_wr_hs),
        .o_rd_ptr  (O_addr),
        .o_wr_ptr  (A_addr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_o_rd_en   <= 1'b0;
            r_a_w_en    <= 1'b0;
            r_sig_end   <= 1'b0;
            r_busy      <= 1'b0;
            r_mode      <= MODE_PASS;
            r_a         <= '0;
            r_b         <= '0;
            r_ld_cnt    <= '0;
            r_cap_row   <= '0;
            r_wr_idx    <= '0;
            r_num_tiles <= '0;
            r_tile_cnt  <= '0;
            r_vld       <= '0;
            for (int unsigned i = 0; i < COL_DIM; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_vld[0] <= r_o_rd_en;
            for (int unsigned i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
            r_sig_end <= 1'b0;
            if (w_cap) begin
                r_stage[r_cap_row] <= data_in;
                r_cap_row          <= r_cap_row + 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (sig_start) begin
                        r_mode      <= mode;
                        r_a         <= A;
                        r_b         <= B;
                        r_num_tiles <= num_tiles;
                        r_tile_cnt  <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_LOAD;
                        r_o_rd_en   <= 1'b1;
                        r_ld_cnt    <= '0;
                        r_cap_row   <= '0;
                        for (int unsigned i = 0; i < COL_DIM; i++) begin
                            r_stage[i] <= '0;
                        end
                    end
                end
                S_LOAD: begin
                    if (r_ld_cnt == r_a) begin
                        r_o_rd_en <= 1'b0;
                        r_state   <= S_WAIT;
                    end else begin
                        r_ld_cnt <= r_ld_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    // Row A lands MEM_RD_LAT cycles after the last read; earlier rows overlap LOAD.
                    if (w_cap && (r_cap_row == r_a)) begin
                        r_state  <= S_DRAIN;
                        r_a_w_en <= 1'b1;
                        r_wr_idx <= '0;
                    end
                end
                S_DRAIN: begin
                    if (w_wr_hs) begin
                        if (r_wr_idx == w_last_idx) begin
                            r_a_w_en <= 1'b0;
                            if (r_tile_cnt == r_num_tiles) begin
                                r_state   <= S_DONE;
                                r_sig_end <= 1'b1;
                            end else begin
                                r_tile_cnt <= r_tile_cnt + 1'b1;
                                r_state    <= S_LOAD;
                                r_o_rd_en  <= 1'b1;
                                r_ld_cnt   <= '0;
                                r_cap_row  <= '0;
                                for (int unsigned i = 0; i < COL_DIM; i++) begin
                                    r_stage[i] <= '0;
                                end
                            end
                        end else begin
                            r_wr_idx <= r_wr_idx + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write data is muxed straight from the staging buffer, which is frozen during DRAIN,
    // so it stays stable across back-pressure without an extra output register.
    always_comb begin
        w_row_mux   = '0;
        w_stage_row = '0;
        if (r_mode == MODE_TRANS) begin
            for (int unsigned i = 0; i < COL_DIM; i++) begin
                w_stage_row = r_stage[i];
                if (i <= 32'(r_a)) begin
                    w_row_mux[i*DW +: DW] = w_stage_row[32'(r_wr_idx)*DW +: DW];
                end
            end
        end else begin
            w_stage_row = r_stage[r_wr_idx[AW-1:0]];
            for (int unsigned k = 0; k < MIN_DIM; k++) begin
                if (k <= 32'(r_b)) begin
                    w_row_mux[k*DW +: DW] = w_stage_row[k*DW +: DW];
                end
            end
        end
    end

    assign data_out = r_a_w_en ? w_row_mux : '0;
    assign O_rd_en  = r_o_rd_en;
    assign A_w_en   = r_a_w_en;
    assign busy     = r_busy;
    assign sig_end  = r_sig_end;

endmodule

// File: tb/tb_intra_net_reshape.sv
// Directed bench for intra_net_reshape: transpose, partial, passthrough wrap,
// back-pressure, async reset mid-drain and start-while-busy at MEM_RD_LAT=3.
module tb_intra_net_reshape;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         start1, start3;
    logic         mode;
    logic [3:0]   cfg_a, cfg_b;
    logic [7:0]   ntiles;
    logic [9:0]   obase, abase;
    logic         A_w_ready;

    logic [127:0] din1, din3, dout1, dout3;
    logic         rden1, rden3, wen1, wen3, busy1, busy3, end1, end3;
    logic [9:0]   oaddr1, oaddr3, aaddr1, aaddr3;

    intra_net_reshape #(.MEM_RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .sig_start(start1), .mode(mode), .A(cfg_a), .B(cfg_b),
        .num_tiles(ntiles), .O_base_addr(obase), .A_base_addr(abase), .data_in(din1),
        .O_rd_en(rden1), .O_addr(oaddr1), .A_w_en(wen1), .A_addr(aaddr1), .data_out(dout1),
        .A_w_ready(A_w_ready), .busy(busy1), .sig_end(end1)
    );

    intra_net_reshape #(.MEM_RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .sig_start(start3), .mode(mode), .A(cfg_a), .B(cfg_b),
        .num_tiles(ntiles), .O_base_addr(obase), .A_base_addr(abase), .data_in(din3),
        .O_rd_en(rden3), .O_addr(oaddr3), .A_w_en(wen3), .A_addr(aaddr3), .data_out(dout3),
        .A_w_ready(A_w_ready), .busy(busy3), .sig_end(end3)
    );

    // O-buffer contents: address a, lane i holds low byte of a*16+i.
    function automatic logic [127:0] orow(input logic [9:0] a);
        logic [127:0] r;
        logic [7:0]   v;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            v = 8'(int'(a) * 16 + i);
            r[i*8 +: 8] = v;
        end
        return r;
    endfunction

    // Expected transposed write j with source rows 0..rows-1 read from addresses 0..rows-1.
    function automatic logic [127:0] tr_row(input int j, input int rows);
        logic [127:0] r;
        logic [7:0]   v;
        r = '0;
        for (int i = 0; i < rows; i++) begin
            v = 8'(i * 16 + j);
            r[i*8 +: 8] = v;
        end
        return r;
    endfunction

    logic [9:0] pa1;
    logic [9:0] p3 [3];
    always @(posedge clk) begin
        pa1   <= oaddr1;
        p3[0] <= oaddr3;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign din1 = orow(pa1);
    assign din3 = orow(p3[2]);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         sel;
    logic         m_rd, m_wen, m_end;
    logic [9:0]   m_oaddr, m_aaddr;
    logic [127:0] m_dout;
    assign m_rd    = sel ? rden3  : rden1;
    assign m_wen   = sel ? wen3   : wen1;
    assign m_end   = sel ? end3   : end1;
    assign m_oaddr = sel ? oaddr3 : oaddr1;
    assign m_aaddr = sel ? aaddr3 : aaddr1;
    assign m_dout  = sel ? dout3  : dout1;

    logic [9:0]   rd_q [$];
    logic [9:0]   wa_q [$];
    logic [127:0] wd_q [$];
    int t0 = 0, first_wen = -1, end_cyc = -1, n_end = 0, n_ovl = 0;
    int n_cmp = 0, n_err = 0;

    always @(negedge clk) begin
        if (m_rd) rd_q.push_back(m_oaddr);
        if (m_wen && A_w_ready) begin
            wa_q.push_back(m_aaddr);
            wd_q.push_back(m_dout);
        end
        if (m_wen && first_wen < 0) first_wen = cyc - t0;
        if (m_end) begin
            n_end++;
            end_cyc = cyc - t0;
        end
        if (m_rd && m_wen) n_ovl++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        rd_q.delete();
        wa_q.delete();
        wd_q.delete();
        first_wen = -1;
        end_cyc   = -1;
        n_end     = 0;
    endtask

    task automatic start_run(input logic which);
        clear_log();
        sel = which;
        @(negedge clk);
        if (which) start3 = 1'b1;
        else       start1 = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int k;
        k = 0;
        while (n_end == 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_end_count"}, 128'(n_end), 128'(1));
    endtask

    task automatic run_full(input string tag, input logic stall);
        mode = 1'b1; cfg_a = 4'd15; cfg_b = 4'd15; ntiles = 8'd0;
        obase = 10'h000; abase = 10'h040; A_w_ready = 1'b1;
        start_run(1'b0);
        chk({tag, "_busy"}, 128'(busy1), 128'(1));
        if (stall) begin
            while (cyc - t0 < 23) begin
                @(posedge clk);
                #1;
            end
            A_w_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
                @(negedge clk);
                chk($sformatf("%s_stall_addr%0d", tag, s), 128'(aaddr1), 128'(10'h045));
                chk($sformatf("%s_stall_data%0d", tag, s), dout1, tr_row(5, 16));
                chk($sformatf("%s_stall_wen%0d", tag, s), 128'(wen1), 128'(1));
                @(posedge clk);
            end
            #1 A_w_ready = 1'b1;
        end
        wait_end(tag);
        chk({tag, "_first_wen"}, 128'(first_wen), 128'(18));
        chk({tag, "_end_cyc"}, 128'(end_cyc), stall ? 128'(37) : 128'(34));
        chk({tag, "_nreads"}, 128'(rd_q.size()), 128'(16));
        chk({tag, "_nwrites"}, 128'(wa_q.size()), 128'(16));
        for (int j = 0; j < 16 && j < wa_q.size(); j++) begin
            chk($sformatf("%s_waddr%0d", tag, j), 128'(wa_q[j]), 128'(10'h040 + j));
            chk($sformatf("%s_wdata%0d", tag, j), wd_q[j], tr_row(j, 16));
        end
    endtask

    initial begin
        logic [9:0] ea;
        reset = 1'b0; start1 = 1'b0; start3 = 1'b0; mode = 1'b0;
        cfg_a = '0; cfg_b = '0; ntiles = '0; obase = '0; abase = '0;
        A_w_ready = 1'b1; sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 128'({rden1, wen1, end1, busy1, rden3, wen3, end3, busy3}), 128'(0));
        chk("rst_addr", 128'({oaddr1, aaddr1, oaddr3, aaddr3}), 128'(0));
        chk("rst_data", dout1 | dout3, 128'(0));
        reset = 1'b1;
        @(negedge clk);

        run_full("full", 1'b0);

        // Partial transpose after a full tile: rows 4..15 must read back as zero.
        mode = 1'b1; cfg_a = 4'd3; cfg_b = 4'd1; ntiles = 8'd0;
        obase = 10'h000; abase = 10'h100;
        start_run(1'b0);
        wait_end("part");
        chk("part_nreads", 128'(rd_q.size()), 128'(4));
        chk("part_nwrites", 128'(wa_q.size()), 128'(2));
        chk("part_first_wen", 128'(first_wen), 128'(6));
        chk("part_end_cyc", 128'(end_cyc), 128'(8));
        for (int j = 0; j < 2 && j < wa_q.size(); j++) begin
            chk($sformatf("part_waddr%0d", j), 128'(wa_q[j]), 128'(10'h100 + j));
            chk($sformatf("part_wdata%0d", j), wd_q[j], tr_row(j, 4));
        end

        mode = 1'b0; cfg_a = 4'd3; cfg_b = 4'd15; ntiles = 8'd1;
        obase = 10'h3FE; abase = 10'h3FC;
        start_run(1'b0);
        wait_end("pass");
        chk("pass_nreads", 128'(rd_q.size()), 128'(8));
        chk("pass_nwrites", 128'(wa_q.size()), 128'(8));
        chk("pass_end_cyc", 128'(end_cyc), 128'(19));
        for (int k = 0; k < 8 && k < rd_q.size(); k++) begin
            ea = 10'h3FE + 10'(k);
            chk($sformatf("pass_raddr%0d", k), 128'(rd_q[k]), 128'(ea));
        end
        for (int k = 0; k < 8 && k < wa_q.size(); k++) begin
            ea = 10'h3FC + 10'(k);
            chk($sformatf("pass_waddr%0d", k), 128'(wa_q[k]), 128'(ea));
            ea = 10'h3FE + 10'(k);
            chk($sformatf("pass_wdata%0d", k), wd_q[k], orow(ea));
        end

        run_full("bp", 1'b1);

        mode = 1'b1; cfg_a = 4'd15; cfg_b = 4'd15; ntiles = 8'd0;
        obase = 10'h000; abase = 10'h040;
        start_run(1'b0);
        while (cyc - t0 < 20) @(negedge clk);
        chk("pre_rst_wen", 128'(wen1), 128'(1));
        reset = 1'b0;
        #1;
        chk("midrst_ctrl", 128'({rden1, wen1, end1, busy1}), 128'(0));
        chk("midrst_addr", 128'({oaddr1, aaddr1}), 128'(0));
        chk("midrst_data", dout1, 128'(0));
        @(negedge clk);
        reset = 1'b1;
        clear_log();
        repeat (6) @(negedge clk);
        chk("midrst_quiet", 128'(rd_q.size() + wa_q.size() + n_end), 128'(0));
        run_full("post_rst", 1'b0);

        mode = 1'b1; cfg_a = 4'd7; cfg_b = 4'd7; ntiles = 8'd0;
        obase = 10'h010; abase = 10'h200;
        start_run(1'b1);
        @(negedge clk);
        mode = 1'b0; cfg_a = 4'd2; cfg_b = 4'd3; obase = 10'h300; abase = 10'h000;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        wait_end("busy_start");
        repeat (10) @(negedge clk);
        chk("busy_start_single_end", 128'(n_end), 128'(1));
        chk("busy_start_first_wen", 128'(first_wen), 128'(12));
        chk("busy_start_end_cyc", 128'(end_cyc), 128'(20));
        chk("busy_start_nreads", 128'(rd_q.size()), 128'(8));
        chk("busy_start_nwrites", 128'(wa_q.size()), 128'(8));
        if (rd_q.size() > 0) chk("busy_start_raddr0", 128'(rd_q[0]), 128'(10'h010));
        for (int j = 0; j < 8 && j < wa_q.size(); j++) begin
            chk($sformatf("busy_start_waddr%0d", j), 128'(wa_q[j]), 128'(10'h200 + j));
            chk($sformatf("busy_start_wdata%0d", j), wd_q[j], tr_row(j, 8));
        end

        chk("no_rd_wr_overlap", 128'(n_ovl), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
